// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: parks on the CPU and grants an external requester in bounded bursts.
// Optional DMEM_ARB_STATS_EN adds stall/ack statistics counters with a synchronous clear.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       ext_cnt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_TURN = 2'd1,
        ST_EXT  = 2'd2
    } state_t;

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic             w_burst_last;

    assign w_burst_last = (r_burst_cnt == BURST_LAST);

    // Read data is shared; each side qualifies it with its own ack / !stall.
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_CPU;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        mem_addr        = cpu_addr;
        mem_wdata       = cpu_wdata;
        mem_we          = 1'b0;
        cpu_stall       = 1'b0;
        ext_ack         = 1'b0;

        case (r_state)
            ST_CPU: begin
                mem_we          = cpu_req & cpu_we;
                w_burst_cnt_nxt = '0;
                if (ext_req) begin
                    w_state_nxt = ST_TURN;
                end
            end
            ST_TURN: begin
                mem_addr        = ext_addr;
                mem_wdata       = ext_wdata;
                cpu_stall       = cpu_req;
                w_burst_cnt_nxt = '0;
                w_state_nxt     = ST_EXT;
            end
            ST_EXT: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_req & ext_we;
                ext_ack   = ext_req;
                cpu_stall = cpu_req;
                // Yield once the burst budget is spent and the CPU is waiting; otherwise saturate.
                if (!ext_req || (cpu_req && w_burst_last)) begin
                    w_state_nxt     = ST_CPU;
                    w_burst_cnt_nxt = '0;
                end else if (!w_burst_last) begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_CPU;
                w_burst_cnt_nxt = '0;
            end
        endcase

        // Reset masks the handshakes combinationally so nothing is written or acked mid-reset.
        if (!reset) begin
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
            ext_ack   = 1'b0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            ext_cnt   <= '0;
        end else if (stats_clr) begin
            stall_cnt <= '0;
            ext_cnt   <= '0;
        end else begin
            if (cpu_stall) stall_cnt <= stall_cnt + 32'd1;
            if (ext_ack)   ext_cnt   <= ext_cnt + 32'd1;
        end
    end
`endif

endmodule
